// File: rtl/axis_pkt_stats_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_stats_pkg
// Description : Shared helpers for the AXI-Stream packet statistics monitor.
//               - sat_add     : saturating add clamped to an arbitrary width.
//               - keep_contig : true when a tkeep value is a non-empty,
//                               low-aligned run of ones (2^k-1, k>=1).
//               - keep_width  : bytes per beat for a given tdata width.
//               - KW          : keep width for the default 256-bit tdata.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkt_stats_pkg;

  localparam int DW_DEFAULT = 256;
  localparam int KW         = DW_DEFAULT / 8;

  function automatic int keep_width(input int dw);
    return dw / 8;
  endfunction

  // Operands are zero-extended to 64 bits by the caller. The result is
  // clamped to 2^w-1 so callers can cast it back down to w bits safely.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (sum > {1'b0, lim}) begin
      return lim;
    end
    return sum[63:0];
  endfunction

  // A low-aligned run of ones plus one has no bits in common with itself.
  // The input is zero-extended by the caller; the all-ones-at-128 case wraps
  // to zero and is correctly reported as contiguous.
  function automatic logic keep_contig(input logic [127:0] k);
    return (k != '0) && ((k & (k + 128'd1)) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_keep_popcount.sv
`default_nettype none
// ============================================================================
// Module      : axis_keep_popcount
// Description : Purely combinational population count of a tkeep vector,
//               built as a balanced adder tree. The input is padded to the
//               next power of two and pairwise-reduced level by level.
// Ports       : keep_i  [KW-1:0]            byte enables
//               count_o [$clog2(KW+1)-1:0]  number of set bits
// Revision    : 1.0 - initial release
// ============================================================================
module axis_keep_popcount #(
  parameter int KW = 32
) (
  input  logic [KW-1:0]            keep_i,
  output logic [$clog2(KW+1)-1:0]  count_o
);

  localparam int OW     = $clog2(KW + 1);
  localparam int LEVELS = (KW > 1) ? $clog2(KW) : 0;
  localparam int LEAVES = 1 << LEVELS;

  logic [LEAVES-1:0] keep_pad;
  logic [OW-1:0]     tree [LEAVES];

  assign keep_pad = LEAVES'(keep_i);

  // In-place pairwise reduction: node j of a level reads nodes 2j and 2j+1
  // of the previous level, which ascending j has not yet overwritten.
  always_comb begin
    for (int j = 0; j < LEAVES; j++) begin
      tree[j] = OW'(keep_pad[j]);
    end
    for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        tree[j] = tree[2*j] + tree[2*j+1];
      end
    end
    count_o = tree[0];
  end

endmodule
`default_nettype wire

// File: rtl/axis_packet_stats.sv
`default_nettype none
// ============================================================================
// Module      : axis_packet_stats
// Description : Passive AXI-Stream statistics monitor. Taps a stream without
//               backpressure and, per completed packet, publishes count,
//               last/min/max size, total bytes and runt/giant counts.
//               Optional macro AXIS_PKT_STATS_KEEP_CHECK_EN adds a per-beat
//               tkeep legality counter (keep_err_count_o).
// Ports       : clk, resetn (sync, active-low)
//               mon_tdata_i/tkeep_i/tlast_i/tvalid_i/tready_i  tapped stream
//               stats_clear_i     1-cycle pulse, zeroes published statistics
//               pkt_done_o        1-cycle pulse with each statistics update
//               packet_count_o, packet_size_o, min_size_o, max_size_o,
//               total_bytes_o, runt_count_o, giant_count_o
//               keep_err_count_o  (only with AXIS_PKT_STATS_KEEP_CHECK_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_stats
  import axis_pkt_stats_pkg::*;
#(
  parameter int DW      = 256,
  parameter int SW      = 16,
  parameter int CW      = 32,
  parameter int TW      = 48,
  parameter int MIN_PKT = 64,
  parameter int MAX_PKT = 1518
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [DW-1:0]   mon_tdata_i,
  input  logic [DW/8-1:0] mon_tkeep_i,
  input  logic            mon_tlast_i,
  input  logic            mon_tvalid_i,
  input  logic            mon_tready_i,
  input  logic            stats_clear_i,
  output logic            pkt_done_o,
  output logic [CW-1:0]   packet_count_o,
  output logic [SW-1:0]   packet_size_o,
  output logic [SW-1:0]   min_size_o,
  output logic [SW-1:0]   max_size_o,
  output logic [TW-1:0]   total_bytes_o,
  output logic [CW-1:0]   runt_count_o,
  output logic [CW-1:0]   giant_count_o
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
  ,
  output logic [CW-1:0]   keep_err_count_o
`endif
);

  localparam int KEEP_W = keep_width(DW);
  localparam int BW     = $clog2(KEEP_W + 1);

  function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
    return CW'(sat_add(64'(v), 64'd1, CW));
  endfunction

  // tdata is carried only so the tap lines up with the stream in waveforms.
  logic w_tdata_unused;
  assign w_tdata_unused = ^mon_tdata_i;

  logic          w_beat;
  logic          w_last_beat;
  logic [BW-1:0] w_beat_bytes;
  logic [SW-1:0] w_size;
  logic          w_is_runt;
  logic          w_is_giant;

  assign w_beat      = mon_tvalid_i & mon_tready_i;
  assign w_last_beat = w_beat & mon_tlast_i;

  axis_keep_popcount #(
    .KW (KEEP_W)
  ) u_popcount (
    .keep_i  (mon_tkeep_i),
    .count_o (w_beat_bytes)
  );

  // ---------------------------------------------------------------------------
  // In-packet accumulator
  // ---------------------------------------------------------------------------
  logic [SW-1:0] partial_q, partial_d;

  // Running size including the current beat; on the last beat this is the
  // packet size.
  assign w_size     = SW'(sat_add(64'(partial_q), 64'(w_beat_bytes), SW));
  assign w_is_runt  = 64'(w_size) < 64'(MIN_PKT);
  assign w_is_giant = 64'(w_size) > 64'(MAX_PKT);

  always_comb begin
    partial_d = partial_q;
    if (w_last_beat) begin
      partial_d = '0;
    end else if (w_beat) begin
      partial_d = w_size;
    end
  end

  // ---------------------------------------------------------------------------
  // Publish stage
  // ---------------------------------------------------------------------------
  logic          pkt_done_q, pkt_done_d;
  logic [CW-1:0] count_q, count_d, base_count;
  logic [SW-1:0] size_q,  size_d,  base_size;
  logic [SW-1:0] min_q,   min_d,   base_min;
  logic [SW-1:0] max_q,   max_d,   base_max;
  logic [TW-1:0] total_q, total_d, base_total;
  logic [CW-1:0] runt_q,  runt_d,  base_runt;
  logic [CW-1:0] giant_q, giant_d, base_giant;

  always_comb begin
    // A clear lands first, so a packet ending in the same cycle becomes the
    // first packet of the fresh statistics window.
    if (stats_clear_i) begin
      base_count = '0;
      base_size  = '0;
      base_min   = '1;
      base_max   = '0;
      base_total = '0;
      base_runt  = '0;
      base_giant = '0;
    end else begin
      base_count = count_q;
      base_size  = size_q;
      base_min   = min_q;
      base_max   = max_q;
      base_total = total_q;
      base_runt  = runt_q;
      base_giant = giant_q;
    end

    pkt_done_d = w_last_beat;
    count_d    = base_count;
    size_d     = base_size;
    min_d      = base_min;
    max_d      = base_max;
    total_d    = base_total;
    runt_d     = base_runt;
    giant_d    = base_giant;

    if (w_last_beat) begin
      count_d = inc_sat(base_count);
      size_d  = w_size;
      min_d   = (w_size < base_min) ? w_size : base_min;
      max_d   = (w_size > base_max) ? w_size : base_max;
      total_d = base_total + TW'(w_size);
      if (w_is_runt) begin
        runt_d = inc_sat(base_runt);
      end
      if (w_is_giant) begin
        giant_d = inc_sat(base_giant);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      partial_q  <= '0;
      pkt_done_q <= 1'b0;
      count_q    <= '0;
      size_q     <= '0;
      min_q      <= '1;
      max_q      <= '0;
      total_q    <= '0;
      runt_q     <= '0;
      giant_q    <= '0;
    end else begin
      partial_q  <= partial_d;
      pkt_done_q <= pkt_done_d;
      count_q    <= count_d;
      size_q     <= size_d;
      min_q      <= min_d;
      max_q      <= max_d;
      total_q    <= total_d;
      runt_q     <= runt_d;
      giant_q    <= giant_d;
    end
  end

  assign pkt_done_o     = pkt_done_q;
  assign packet_count_o = count_q;
  assign packet_size_o  = size_q;
  assign min_size_o     = min_q;
  assign max_size_o     = max_q;
  assign total_bytes_o  = total_q;
  assign runt_count_o   = runt_q;
  assign giant_count_o  = giant_q;

`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
  // ---------------------------------------------------------------------------
  // tkeep legality: inner beats must be full, last beats low-aligned and
  // non-empty. Counted per offending beat; sizes are unaffected.
  // ---------------------------------------------------------------------------
  logic          w_keep_bad;
  logic [CW-1:0] keep_err_q, keep_err_d;

  assign w_keep_bad = w_beat & (mon_tlast_i ? !keep_contig(128'(mon_tkeep_i))
                                            : (mon_tkeep_i != '1));

  always_comb begin
    keep_err_d = stats_clear_i ? '0 : keep_err_q;
    if (w_keep_bad) begin
      keep_err_d = inc_sat(keep_err_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      keep_err_q <= '0;
    end else begin
      keep_err_q <= keep_err_d;
    end
  end

  assign keep_err_count_o = keep_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_stats.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_packet_stats
// Description : Scoreboard bench for axis_packet_stats (DW=64). Three DUTs
//               share one stimulus stream: default sizing, SW=8 and CW=4.
//               The driver updates a byte-count reference model and queues
//               expected statistics; per-DUT monitors compare on pkt_done.
//               Exercises keep_err_count when AXIS_PKT_STATS_KEEP_CHECK_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_packet_stats;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, tvalid, tready, tlast, sclr;
  logic [63:0] tdata;
  logic [7:0]  tkeep;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic p0_done, p1_done, p2_done;
  logic [31:0] p0_cnt, p0_runt, p0_giant, p1_cnt, p1_runt, p1_giant;
  logic [3:0]  p2_cnt, p2_runt, p2_giant;
  logic [15:0] p0_size, p0_min, p0_max, p2_size, p2_min, p2_max;
  logic [7:0]  p1_size, p1_min, p1_max;
  logic [47:0] p0_tot, p1_tot, p2_tot;
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
  logic [31:0] p0_kerr, p1_kerr;
  logic [3:0]  p2_kerr;
`endif

  axis_packet_stats #(.DW(64)) u_dut0 (
    .clk(clk), .resetn(resetn), .mon_tdata_i(tdata), .mon_tkeep_i(tkeep),
    .mon_tlast_i(tlast), .mon_tvalid_i(tvalid), .mon_tready_i(tready),
    .stats_clear_i(sclr), .pkt_done_o(p0_done), .packet_count_o(p0_cnt),
    .packet_size_o(p0_size), .min_size_o(p0_min), .max_size_o(p0_max),
    .total_bytes_o(p0_tot), .runt_count_o(p0_runt), .giant_count_o(p0_giant)
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
    , .keep_err_count_o(p0_kerr)
`endif
  );

  axis_packet_stats #(.DW(64), .SW(8)) u_dut1 (
    .clk(clk), .resetn(resetn), .mon_tdata_i(tdata), .mon_tkeep_i(tkeep),
    .mon_tlast_i(tlast), .mon_tvalid_i(tvalid), .mon_tready_i(tready),
    .stats_clear_i(sclr), .pkt_done_o(p1_done), .packet_count_o(p1_cnt),
    .packet_size_o(p1_size), .min_size_o(p1_min), .max_size_o(p1_max),
    .total_bytes_o(p1_tot), .runt_count_o(p1_runt), .giant_count_o(p1_giant)
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
    , .keep_err_count_o(p1_kerr)
`endif
  );

  axis_packet_stats #(.DW(64), .CW(4)) u_dut2 (
    .clk(clk), .resetn(resetn), .mon_tdata_i(tdata), .mon_tkeep_i(tkeep),
    .mon_tlast_i(tlast), .mon_tvalid_i(tvalid), .mon_tready_i(tready),
    .stats_clear_i(sclr), .pkt_done_o(p2_done), .packet_count_o(p2_cnt),
    .packet_size_o(p2_size), .min_size_o(p2_min), .max_size_o(p2_max),
    .total_bytes_o(p2_tot), .runt_count_o(p2_runt), .giant_count_o(p2_giant)
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
    , .keep_err_count_o(p2_kerr)
`endif
  );

  typedef struct {
    logic [63:0] cyc, cnt, size, mn, mx, tot, runt, giant, kerr;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    n_err++;
    $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  task automatic compare_fields(input string tag, input exp_t e, input exp_t a);
    check({tag, ".cycle"}, a.cyc,   e.cyc);
    check({tag, ".count"}, a.cnt,   e.cnt);
    check({tag, ".size"},  a.size,  e.size);
    check({tag, ".min"},   a.mn,    e.mn);
    check({tag, ".max"},   a.mx,    e.mx);
    check({tag, ".total"}, a.tot,   e.tot);
    check({tag, ".runt"},  a.runt,  e.runt);
    check({tag, ".giant"}, a.giant, e.giant);
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
    check({tag, ".keep_err"}, a.kerr, e.kerr);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: raw byte sum per packet, sizes clamped at publish time.
  // ---------------------------------------------------------------------------
  int SWS[3] = '{16, 8, 16};
  int CWS[3] = '{32, 32, 4};
  longint m_cnt[3], m_size[3], m_min[3], m_max[3], m_tot[3], m_runt[3], m_giant[3];
  longint m_kerr, acc;

  function automatic longint lim(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  task automatic model_clear();
    for (int id = 0; id < 3; id++) begin
      m_cnt[id] = 0; m_size[id] = 0; m_min[id] = lim(SWS[id]); m_max[id] = 0;
      m_tot[id] = 0; m_runt[id] = 0; m_giant[id] = 0;
    end
    m_kerr = 0;
  endtask

  task automatic model_publish();
    for (int id = 0; id < 3; id++) begin
      longint s;
      exp_t e;
      s = (acc > lim(SWS[id])) ? lim(SWS[id]) : acc;
      if (m_cnt[id] < lim(CWS[id])) m_cnt[id]++;
      m_size[id] = s;
      if (s < m_min[id]) m_min[id] = s;
      if (s > m_max[id]) m_max[id] = s;
      m_tot[id] = (m_tot[id] + s) % (longint'(1) << 48);
      if (s < 64   && m_runt[id]  < lim(CWS[id])) m_runt[id]++;
      if (s > 1518 && m_giant[id] < lim(CWS[id])) m_giant[id]++;
      e.cyc = cyc; e.cnt = m_cnt[id]; e.size = m_size[id]; e.mn = m_min[id];
      e.mx = m_max[id]; e.tot = m_tot[id]; e.runt = m_runt[id];
      e.giant = m_giant[id]; e.kerr = (m_kerr > lim(CWS[id])) ? lim(CWS[id]) : m_kerr;
      case (id)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic model_step(input logic rn, input logic v, input logic r,
                            input logic l, input logic [7:0] k, input logic clr);
    if (!rn) begin
      acc = 0;
      model_clear();
    end else begin
      if (clr) model_clear();
      if (v && r) begin
        if (l ? !(k inside {8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF})
              : (k != 8'hFF)) begin
          if (m_kerr < lim(32)) m_kerr++;
        end
        acc += $countones(k);
        if (l) begin
          model_publish();
          acc = 0;
        end
      end
    end
  endtask

  // One clock of stimulus; model follows the edge that samples it.
  task automatic cyc_drive(input logic rn, input logic v, input logic r,
                           input logic l, input logic [7:0] k, input logic clr);
    resetn = rn; tvalid = v; tready = r; tlast = l; tkeep = k; sclr = clr;
    tdata  = {$urandom, $urandom};
    @(posedge clk);
    #1;
    model_step(rn, v, r, l, k, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_pkt(input int size, input bit clr_last, input bit rnd);
    int nb;
    nb = (size == 0) ? 1 : (size + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      bit last;
      int rem;
      logic [7:0] k;
      last = (b == nb - 1);
      rem  = size - 8 * b;
      k    = (!last || rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      if (rnd) begin
        while ($urandom_range(0, 2) == 0) begin
          logic v;
          v = 1'($urandom_range(0, 1));
          cyc_drive(1'b1, v, !v, 1'($urandom), 8'($urandom), 1'b0);
        end
      end
      cyc_drive(1'b1, 1'b1, 1'b1, last, k, clr_last && last);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e, a;
    a.cyc = cyc; a.cnt = p0_cnt; a.size = p0_size; a.mn = p0_min; a.mx = p0_max;
    a.tot = p0_tot; a.runt = p0_runt; a.giant = p0_giant; a.kerr = '0;
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
    a.kerr = p0_kerr;
`endif
    if (p0_done === 1'b1) begin
      if (q0.size() == 0) fail_now("dut0 spurious pkt_done", 1, 0);
      else begin e = q0.pop_front(); compare_fields("dut0", e, a); end
    end else if (q0.size() != 0 && q0[0].cyc < 64'(cyc)) begin
      e = q0.pop_front();
      fail_now("dut0 missing pkt_done", 0, 1);
    end
  end

  always @(negedge clk) begin
    exp_t e, a;
    a.cyc = cyc; a.cnt = p1_cnt; a.size = p1_size; a.mn = p1_min; a.mx = p1_max;
    a.tot = p1_tot; a.runt = p1_runt; a.giant = p1_giant; a.kerr = '0;
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
    a.kerr = p1_kerr;
`endif
    if (p1_done === 1'b1) begin
      if (q1.size() == 0) fail_now("dut1 spurious pkt_done", 1, 0);
      else begin e = q1.pop_front(); compare_fields("dut1", e, a); end
    end else if (q1.size() != 0 && q1[0].cyc < 64'(cyc)) begin
      e = q1.pop_front();
      fail_now("dut1 missing pkt_done", 0, 1);
    end
  end

  always @(negedge clk) begin
    exp_t e, a;
    a.cyc = cyc; a.cnt = p2_cnt; a.size = p2_size; a.mn = p2_min; a.mx = p2_max;
    a.tot = p2_tot; a.runt = p2_runt; a.giant = p2_giant; a.kerr = '0;
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
    a.kerr = p2_kerr;
`endif
    if (p2_done === 1'b1) begin
      if (q2.size() == 0) fail_now("dut2 spurious pkt_done", 1, 0);
      else begin e = q2.pop_front(); compare_fields("dut2", e, a); end
    end else if (q2.size() != 0 && q2[0].cyc < 64'(cyc)) begin
      e = q2.pop_front();
      fail_now("dut2 missing pkt_done", 0, 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic check_cleared(input string tag);
    check({tag, " count"},     p0_cnt,   0);
    check({tag, " size"},      p0_size,  0);
    check({tag, " min"},       p0_min,   16'hFFFF);
    check({tag, " max"},       p0_max,   0);
    check({tag, " total"},     p0_tot,   0);
    check({tag, " runt"},      p0_runt,  0);
    check({tag, " giant"},     p0_giant, 0);
    check({tag, " pkt_done"},  p0_done,  0);
    check({tag, " sw8 min"},   p1_min,   8'hFF);
    check({tag, " cw4 count"}, p2_cnt,   0);
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
    check({tag, " keep_err"},  p0_kerr,  0);
`endif
  endtask

  initial begin
    // Reset, with beats offered while in reset that must be ignored.
    cyc_drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
    cyc_drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
    cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_cleared("reset");

    // 3 full beats + last tkeep 0x0F -> 28 B runt.
    for (int i = 0; i < 3; i++) cyc_drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
    cyc_drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0);
    check("t1 size", p0_size, 28);
    check("t1 runt", p0_runt, 1);
    idle(1);
    check("t1 pkt_done one cycle", p0_done, 0);

    // Standalone clear, then 100/64/1600 with random flow control.
    cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_cleared("clear");
    send_pkt(100, 1'b0, 1'b1);
    send_pkt(64, 1'b0, 1'b1);
    send_pkt(1600, 1'b0, 1'b1);
    idle(2);
    check("t2 count", p0_cnt, 3);
    check("t2 min", p0_min, 64);
    check("t2 max", p0_max, 1600);
    check("t2 total", p0_tot, 1764);
    check("t2 giant", p0_giant, 1);

    // Clear coincident with the last beat of a 200 B packet.
    send_pkt(200, 1'b1, 1'b1);
    check("t3 count", p0_cnt, 1);
    check("t3 min", p0_min, 200);
    check("t3 max", p0_max, 200);
    check("t3 total", p0_tot, 200);

    // Reset mid-packet after 5 beats.
    for (int i = 0; i < 5; i++) cyc_drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
    cyc_drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
    cyc_drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
    cyc_drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
    check("t4 size", p0_size, 16);
    check("t4 count", p0_cnt, 1);

    // Size saturation (SW=8) and count saturation (CW=4).
    cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    send_pkt(328, 1'b0, 1'b0);
    check("t5 sw8 size", p1_size, 255);
    check("t5 sw16 size", p0_size, 328);
    for (int i = 0; i < 20; i++) send_pkt($urandom_range(0, 8), 1'b0, 1'b1);
    idle(1);
    check("t5 cw4 count", p2_cnt, 15);
    check("t5 cw32 count", p0_cnt, 21);

    // Illegal tkeep on both an inner and a last beat.
    cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc_drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b0);
    cyc_drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0);
    check("t6 size", p0_size, 9);
`ifdef AXIS_PKT_STATS_KEEP_CHECK_EN
    check("t6 keep_err", p0_kerr, 2);
`endif

    // Random raw stream with occasional clears, then random-size packets.
    for (int i = 0; i < 400; i++) begin
      cyc_drive(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 5) == 0), 8'($urandom), 1'($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 8; i++) send_pkt($urandom_range(0, 2000), 1'b0, 1'b1);

    idle(3);
    check("dut0 queue drained", 64'(q0.size()), 0);
    check("dut1 queue drained", 64'(q1.size()), 0);
    check("dut2 queue drained", 64'(q2.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
